// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode/funct encodings, ALU control codes and the
// EX-stage control bundle used by the ID/EX stage and its decoder.
package mips_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // ALU control codes understood by the downstream ALU
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_BNE  = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_SLT  = 4'b1101;
    localparam logic [3:0] ALU_SLTU = 4'b1110;

    // Control carried alongside the operands into EX/MEM
    typedef struct packed {
        logic [3:0] alu_cntl;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       illegal;
    } ex_ctrl_t;

    // Full decode result: EX control plus operand/destination steering
    typedef struct packed {
        ex_ctrl_t ctrl;
        logic     imm_zext;    // zero- rather than sign-extend imm
        logic     b_is_imm;    // ALU B takes the immediate
        logic     use_rs;
        logic     use_rt;
        logic     dest_is_rd;  // R-type writes rd, I-type writes rt
    } dec_t;

endpackage

// File: rtl/alu_cntl_decoder.sv
// alu_cntl_decoder: combinational opcode/funct decode into ALU control,
// immediate mode, source usage, destination select and illegal flag.
module alu_cntl_decoder
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output dec_t       dec
);

    // Decode one instruction; unknown encodings fall back to a harmless add
    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves one unassigned (no latch).
        dec               = '0;
        dec.ctrl.alu_cntl = ALU_ADD;
        dec.use_rs        = 1'b1;
        dec.b_is_imm      = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                dec.use_rt         = 1'b1;
                dec.b_is_imm       = 1'b0;
                dec.dest_is_rd     = 1'b1;
                dec.ctrl.reg_write = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: dec.ctrl.alu_cntl = ALU_ADD;
                    FN_SUB, FN_SUBU: dec.ctrl.alu_cntl = ALU_SUB;
                    FN_AND:          dec.ctrl.alu_cntl = ALU_AND;
                    FN_OR:           dec.ctrl.alu_cntl = ALU_OR;
                    FN_XOR:          dec.ctrl.alu_cntl = ALU_XOR;
                    FN_NOR:          dec.ctrl.alu_cntl = ALU_NOR;
                    FN_SLT:          dec.ctrl.alu_cntl = ALU_SLT;
                    FN_SLTU:         dec.ctrl.alu_cntl = ALU_SLTU;
                    default: begin
                        dec.ctrl.illegal   = 1'b1;
                        dec.ctrl.reg_write = 1'b0;
                        dec.use_rs         = 1'b0;
                        dec.use_rt         = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU: dec.ctrl.reg_write = 1'b1;
            OP_SLTI: begin
                dec.ctrl.alu_cntl  = ALU_SLT;
                dec.ctrl.reg_write = 1'b1;
            end
            OP_SLTIU: begin
                dec.ctrl.alu_cntl  = ALU_SLTU;
                dec.ctrl.reg_write = 1'b1;
            end
            OP_ANDI: begin
                dec.ctrl.alu_cntl  = ALU_AND;
                dec.ctrl.reg_write = 1'b1;
                dec.imm_zext       = 1'b1;
            end
            OP_ORI: begin
                dec.ctrl.alu_cntl  = ALU_OR;
                dec.ctrl.reg_write = 1'b1;
                dec.imm_zext       = 1'b1;
            end
            OP_XORI: begin
                dec.ctrl.alu_cntl  = ALU_XOR;
                dec.ctrl.reg_write = 1'b1;
                dec.imm_zext       = 1'b1;
            end
            OP_LW: begin
                dec.ctrl.reg_write = 1'b1;
                dec.ctrl.mem_read  = 1'b1;
            end
            OP_SW: begin
                dec.ctrl.mem_write = 1'b1;
                dec.use_rt         = 1'b1;
            end
            OP_BEQ: begin
                dec.ctrl.alu_cntl = ALU_SUB;
                dec.use_rt        = 1'b1;
                dec.b_is_imm      = 1'b0;
            end
            OP_BNE: begin
                dec.ctrl.alu_cntl = ALU_BNE;
                dec.use_rt        = 1'b1;
                dec.b_is_imm      = 1'b0;
            end
            default: begin
                dec.ctrl.illegal = 1'b1;
                dec.use_rs       = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register in front of the 32-bit ALU.
// Decodes, extends immediates, selects operands and stalls decode on hazards.
// Build option: FORWARDING_EN adds EX/MEM/WB forwarding so only load-use
// stalls; without it the stage stalls on any EX or MEM destination match.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               id_valid,
    output logic               id_ready,
    input  logic [31:0]        id_instr,
    input  logic [DATA_W-1:0]  id_rs_data,
    input  logic [DATA_W-1:0]  id_rt_data,
    input  logic               flush,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               mem_wr_en,
    input  logic [RADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0]  mem_data,
    input  logic               wb_wr_en,
    input  logic [RADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [3:0]         alu_cntl,
    output logic               alu_carry_in,
    output logic               ex_valid,
    output logic [RADDR_W-1:0] ex_dest,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic [DATA_W-1:0]  ex_store_data,
    output logic               ex_illegal
);

    logic [RADDR_W-1:0] rs_addr, rt_addr, rd_addr, dest;
    logic [DATA_W-1:0]  imm_ext, rs_val, rt_val;
    dec_t               dec;
    ex_ctrl_t           ctrl_d, ctrl_q;
    logic               rs_ex_hit, rt_ex_hit, stall, accept;

    assign rs_addr = id_instr[25:21];
    assign rt_addr = id_instr[20:16];
    assign rd_addr = id_instr[15:11];

    alu_cntl_decoder u_dec (
        .opcode (id_instr[31:26]),
        .funct  (id_instr[5:0]),
        .dec    (dec)
    );

    assign dest    = dec.dest_is_rd ? rd_addr : rt_addr;
    assign imm_ext = {{(DATA_W-16){id_instr[15] & ~dec.imm_zext}}, id_instr[15:0]};

    // Register 0 is never written, so suppress its write enable
    always_comb begin
        ctrl_d           = dec.ctrl;
        ctrl_d.reg_write = dec.ctrl.reg_write && (dest != '0);
    end

    // Used sources that the held EX instruction is about to overwrite
    assign rs_ex_hit = dec.use_rs && (rs_addr != '0) && ctrl_q.reg_write && (ex_dest == rs_addr);
    assign rt_ex_hit = dec.use_rt && (rt_addr != '0) && ctrl_q.reg_write && (ex_dest == rt_addr);

`ifdef FORWARDING_EN
    logic unused_instr;
    assign unused_instr = ^id_instr[10:6];

    // Only a load in EX cannot be forwarded yet
    assign stall = ctrl_q.mem_read && (rs_ex_hit || rt_ex_hit);

    // Forward rs: EX result first, then MEM, then WB, else register file
    always_comb begin
        rs_val = id_rs_data;
        if (rs_ex_hit)                                                       rs_val = alu_result;
        else if (dec.use_rs && rs_addr != '0 && mem_wr_en && mem_addr == rs_addr) rs_val = mem_data;
        else if (dec.use_rs && rs_addr != '0 && wb_wr_en && wb_addr == rs_addr)   rs_val = wb_data;
    end

    // Forward rt with the same priority
    always_comb begin
        rt_val = id_rt_data;
        if (rt_ex_hit)                                                       rt_val = alu_result;
        else if (dec.use_rt && rt_addr != '0 && mem_wr_en && mem_addr == rt_addr) rt_val = mem_data;
        else if (dec.use_rt && rt_addr != '0 && wb_wr_en && wb_addr == rt_addr)   rt_val = wb_data;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{id_instr[10:6], alu_result, mem_data, wb_wr_en, wb_addr, wb_data};

    // Register file is write-first, so only EX and MEM writers need to drain
    assign stall = rs_ex_hit || rt_ex_hit
                || (dec.use_rs && rs_addr != '0 && mem_wr_en && mem_addr == rs_addr)
                || (dec.use_rt && rt_addr != '0 && mem_wr_en && mem_addr == rt_addr);
    assign rs_val = id_rs_data;
    assign rt_val = id_rt_data;
`endif

    // A flush discards the incoming instruction, so it also releases a stall
    assign id_ready = flush || !(id_valid && stall);
    assign accept   = id_valid && !stall && !flush;

    // Capture the accepted instruction, otherwise load a bubble
    always_ff @(posedge clk) begin
        // NOTE: operand registers are cleared too, since every output must read 0 after reset and in a bubble.
        if (reset || !accept) begin
            // NOTE: non-blocking assignments keep all state updates in step at the clock edge.
            ctrl_q        <= '0;
            ex_valid      <= 1'b0;
            ex_dest       <= '0;
            alu_a         <= '0;
            alu_b         <= '0;
            ex_store_data <= '0;
        end else begin
            ctrl_q        <= ctrl_d;
            ex_valid      <= 1'b1;
            ex_dest       <= dest;
            alu_a         <= rs_val;
            alu_b         <= dec.b_is_imm ? imm_ext : rt_val;
            ex_store_data <= rt_val;
        end
    end

    assign alu_cntl     = ctrl_q.alu_cntl;
    assign ex_reg_write = ctrl_q.reg_write;
    assign ex_mem_read  = ctrl_q.mem_read;
    assign ex_mem_write = ctrl_q.mem_write;
    assign ex_illegal   = ctrl_q.illegal;
    assign alu_carry_in = 1'b0;

endmodule
